// File: rtl/piso_ctrl_pkg.sv
// Shared definitions for the PISO transmit controller: FSM encodings and width helper.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package piso_ctrl_pkg;

  // FSM state encodings, kept as plain constants so legacy code can match on them.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  // Width of a counter that must hold values 0..n-1; never narrower than one bit
  // so that degenerate parameter values (n of 0, 1 or 2) still elaborate cleanly.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_nbit_shift_reg.sv
// Parallel-load, right-shifting register; q_out presents bit 0 (LSB-first serialization).
// Latency: load visible on q_out one clock after the load edge.
// Backpressure: none; loads whenever s_lbar is low, otherwise shifts every clock with zero fill.
module piso_nbit_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_bar,
  input  logic             s_lbar,
  input  logic [WIDTH-1:0] din,
  output logic             q_out
);

  logic [WIDTH-1:0] sreg;

  // Load on s_lbar=0, otherwise shift right; zero fill keeps an idle register at zero.
  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) begin
      sreg <= '0;
    end else if (!s_lbar) begin
      sreg <= din;
    end else begin
      sreg <= {1'b0, sreg[WIDTH-1:1]};
    end
  end

  assign q_out = sreg[0];

endmodule

// File: rtl/piso_tx_ctrl.sv
// Serializes WIDTH-bit words LSB first with frame markers and an optional idle gap between frames.
// Latency: word accepted at edge k -> load cycle k+1 -> bit 0 on ser_out in cycle k+2.
// Backpressure: single hold buffer; in_ready drops while it is full and rises after the word is loaded.
module piso_tx_ctrl
  import piso_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rst_bar,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             s_lbar,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);
  localparam int GW = cnt_width(GAP);

  // Terminal counts; GAP_LAST is only meaningful when GAP is non-zero.
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic          GAP_ZERO = (GAP == 0);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [GW-1:0]    gap_cnt;
  logic [WIDTH-1:0] hold_dat;
  logic             hold_full;
  logic             load;
  logic             handshake;
  logic             shifting;
  logic             q_out;

  // Ready comes straight from the full flag so in_valid never loops back into in_ready.
  assign in_ready  = ~hold_full;
  assign handshake = in_valid & ~hold_full;
  assign shifting  = (state == ST_SHIFT);

  // A waiting word moves into the shifter when the line is free: from idle, back-to-back
  // on the final bit when no gap is wanted, or on the final gap cycle.
  always_comb begin
    load = 1'b0;
    if (hold_full) begin
      case (state)
        ST_IDLE:  load = 1'b1;
        ST_SHIFT: load = (cnt == CNT_LAST) && GAP_ZERO;
        ST_GAP:   load = (gap_cnt == GAP_LAST);
        default:  load = 1'b0;
      endcase
    end
  end

  assign s_lbar = ~load;

  // Hold buffer: capture on handshake, release on load. The two cannot coincide because
  // a load needs hold_full=1, which also holds in_ready low.
  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) begin
      hold_full <= 1'b0;
      hold_dat  <= '0;
    end else if (handshake) begin
      hold_full <= 1'b1;
      hold_dat  <= in_data;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  end

  // Frame sequencing: bit counter during SHIFT, gap counter during GAP.
  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      gap_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load) begin
            state <= ST_SHIFT;
            cnt   <= '0;
          end
        end
        ST_SHIFT: begin
          if (load) begin
            // Next frame follows immediately; stay in SHIFT and restart the bit count.
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (GAP_ZERO) begin
              state <= ST_IDLE;
            end else begin
              state   <= ST_GAP;
              gap_cnt <= '0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_GAP: begin
          if (load) begin
            state <= ST_SHIFT;
            cnt   <= '0;
          end else if (gap_cnt == GAP_LAST) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  piso_nbit_shift_reg #(
    .WIDTH(WIDTH)
  ) u_sreg (
    .clk    (clk),
    .rst_bar(rst_bar),
    .s_lbar (s_lbar),
    .din    (hold_dat),
    .q_out  (q_out)
  );

  // Serial outputs are forced low outside SHIFT so idle and gap cycles read as all zero.
  assign ser_valid = shifting;
  assign ser_out   = shifting & q_out;
  assign ser_first = shifting & (cnt == '0);
  assign ser_last  = shifting & (cnt == CNT_LAST);
  assign busy      = (state != ST_IDLE) | hold_full;

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Self-checking bench for piso_tx_ctrl: three instances (W4/G0, W4/G2, W8/G0) against a
// frame-timing model; time t counts rising edges, outputs are sampled on the falling edge.
// Each accepted word at edge E occupies bits S..S+W-1 with S = max(E+1, prev_last+GAP+1).
module tb_piso_tx_ctrl;

  logic       clk     = 1'b0;
  logic       rst_bar = 1'b0;
  logic [2:0] vin     = '0;
  logic [7:0] din [3];
  logic [2:0] rdy, slb, so, sv, sf, sl, bsy;

  int nchk = 0;
  int nerr = 0;
  int t    = 0;

  always #5 clk = ~clk;

  piso_tx_ctrl #(.WIDTH(4), .GAP(0)) u0 (
    .clk(clk), .rst_bar(rst_bar), .in_valid(vin[0]), .in_data(din[0][3:0]),
    .in_ready(rdy[0]), .s_lbar(slb[0]), .ser_out(so[0]), .ser_valid(sv[0]),
    .ser_first(sf[0]), .ser_last(sl[0]), .busy(bsy[0]));

  piso_tx_ctrl #(.WIDTH(4), .GAP(2)) u1 (
    .clk(clk), .rst_bar(rst_bar), .in_valid(vin[1]), .in_data(din[1][3:0]),
    .in_ready(rdy[1]), .s_lbar(slb[1]), .ser_out(so[1]), .ser_valid(sv[1]),
    .ser_first(sf[1]), .ser_last(sl[1]), .busy(bsy[1]));

  piso_tx_ctrl #(.WIDTH(8), .GAP(0)) u2 (
    .clk(clk), .rst_bar(rst_bar), .in_valid(vin[2]), .in_data(din[2]),
    .in_ready(rdy[2]), .s_lbar(slb[2]), .ser_out(so[2]), .ser_valid(sv[2]),
    .ser_first(sf[2]), .ser_last(sl[2]), .busy(bsy[2]));

  function automatic int wd(input int i);
    return (i == 2) ? 8 : 4;
  endfunction

  function automatic int gp(input int i);
    return (i == 1) ? 2 : 0;
  endfunction

  // Reference model: most recent frame (cur) and the one before it (prv).
  int         s_last [3];
  int         l_last [3];
  int         fs_cur [3];
  int         fs_prv [3];
  logic [7:0] fd_cur [3];
  logic [7:0] fd_prv [3];
  int         acc_cnt [3];
  int         acc_t [3];

  // Observation log for the directed literal checks.
  logic [15:0] obs_bits [3];
  int obs_n [3];
  int obs_fc [3];
  int obs_lc [3];
  int obs_f0 [3];
  int obs_f1 [3];
  int obs_l0 [3];
  int obs_ll [3];

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      s_last[i] = -1000;
      l_last[i] = -1000;
      fs_cur[i] = -1000;
      fs_prv[i] = -1000;
      fd_cur[i] = '0;
      fd_prv[i] = '0;
    end
  endtask

  task automatic clear_obs(input int i);
    obs_bits[i] = '0;
    obs_n[i]    = 0;
    obs_fc[i]   = 0;
    obs_lc[i]   = 0;
    obs_f0[i]   = -1;
    obs_f1[i]   = -1;
    obs_l0[i]   = -1;
    obs_ll[i]   = -1;
  endtask

  task automatic chk(input string nm, input int i, input logic act, input logic want);
    nchk++;
    if (act !== want) begin
      nerr++;
      $display("FAIL %s inst%0d t=%0d got=%b want=%b", nm, i, t, act, want);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int want);
    nchk++;
    if (act != want) begin
      nerr++;
      $display("FAIL %s t=%0d got=%0d want=%0d", nm, t, act, want);
    end
  endtask

  always @(negedge rst_bar) model_clear();

  // Handshake bookkeeping at each rising edge; ready is the model's own prediction.
  always @(posedge clk) begin
    t = t + 1;
    if (rst_bar) begin
      for (int i = 0; i < 3; i++) begin
        if (vin[i] && (t - 1 >= s_last[i])) begin
          int s;
          s = l_last[i] + gp(i) + 1;
          if (t + 1 > s) s = t + 1;
          fs_prv[i] = fs_cur[i];
          fd_prv[i] = fd_cur[i];
          fs_cur[i] = s;
          fd_cur[i] = din[i];
          s_last[i] = s;
          l_last[i] = s + wd(i) - 1;
          acc_cnt[i]++;
          acc_t[i] = t;
        end
      end
    end
  end

  // Every-cycle comparison against the model, plus logging.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      logic ev, eo, ef, el;
      ev = 1'b0; eo = 1'b0; ef = 1'b0; el = 1'b0;
      if (t >= fs_cur[i] && t < fs_cur[i] + wd(i)) begin
        ev = 1'b1;
        eo = fd_cur[i][t - fs_cur[i]];
        ef = (t == fs_cur[i]);
        el = (t == fs_cur[i] + wd(i) - 1);
      end else if (t >= fs_prv[i] && t < fs_prv[i] + wd(i)) begin
        ev = 1'b1;
        eo = fd_prv[i][t - fs_prv[i]];
        ef = (t == fs_prv[i]);
        el = (t == fs_prv[i] + wd(i) - 1);
      end
      chk("in_ready",  i, rdy[i], t >= s_last[i]);
      chk("s_lbar",    i, slb[i], !(t == s_last[i] - 1));
      chk("ser_valid", i, sv[i],  ev);
      chk("ser_out",   i, so[i],  eo);
      chk("ser_first", i, sf[i],  ef);
      chk("ser_last",  i, sl[i],  el);
      chk("busy",      i, bsy[i], (t < s_last[i]) || (t <= l_last[i] + gp(i)));
      if (sv[i]) begin
        if (obs_n[i] < 16) obs_bits[i][obs_n[i]] = so[i];
        obs_n[i]++;
      end
      if (sf[i]) begin
        if (obs_fc[i] == 0) obs_f0[i] = t;
        else if (obs_fc[i] == 1) obs_f1[i] = t;
        obs_fc[i]++;
      end
      if (sl[i]) begin
        if (obs_lc[i] == 0) obs_l0[i] = t;
        obs_ll[i] = t;
        obs_lc[i]++;
      end
    end
  end

  task automatic send(input int i, input logic [7:0] d);
    int c0;
    c0 = acc_cnt[i];
    din[i] = d;
    vin[i] = 1'b1;
    for (int k = 0; k < 40 && acc_cnt[i] == c0; k++) @(negedge clk);
    vin[i] = 1'b0;
    if (acc_cnt[i] == c0) begin
      nchk++;
      nerr++;
      $display("FAIL send_timeout inst%0d data=%h", i, d);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0d", t);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, prev, e0, dens;
    for (int i = 0; i < 3; i++) begin
      din[i]     = '0;
      acc_cnt[i] = 0;
      acc_t[i]   = 0;
      clear_obs(i);
    end
    model_clear();

    // Reset values while rst_bar is held low.
    #12;
    for (int i = 0; i < 3; i++) begin
      chk("rst_ready", i, rdy[i], 1'b1);
      chk("rst_s_lbar", i, slb[i], 1'b1);
      chk("rst_busy", i, bsy[i], 1'b0);
      chk("rst_valid", i, sv[i], 1'b0);
      chk("rst_out", i, so[i], 1'b0);
    end
    @(negedge clk);
    #2 rst_bar = 1'b1;

    // Single word 1011 from idle.
    clear_obs(0);
    send(0, 8'h0B);
    e0 = acc_t[0];
    wait_cycles(8);
    chk_int("d1_nbits", obs_n[0], 4);
    chk_int("d1_bits", int'(obs_bits[0][3:0]), 4'b1011);
    chk_int("d1_first_lat", obs_f0[0] - e0, 1);
    chk_int("d1_last_lat", obs_l0[0] - e0, 4);
    chk("d1_idle", 0, bsy[0], 1'b0);

    // Back-to-back A then 5, no gap.
    clear_obs(0);
    send(0, 8'h0A);
    send(0, 8'h05);
    wait_cycles(10);
    chk_int("d2_nbits", obs_n[0], 8);
    chk_int("d2_bits", int'(obs_bits[0][7:0]), 8'h5A);
    chk_int("d2_firsts", obs_fc[0], 2);
    chk_int("d2_span", obs_ll[0] - obs_f0[0] + 1, 8);

    // Two words with GAP=2.
    clear_obs(1);
    send(1, 8'h09);
    send(1, 8'h06);
    wait_cycles(16);
    chk_int("d3_nbits", obs_n[1], 8);
    chk_int("d3_gap", obs_f1[1] - obs_l0[1] - 1, 2);

    // in_valid held, data changing every cycle.
    clear_obs(0);
    c0   = acc_cnt[0];
    prev = c0;
    vin[0] = 1'b1;
    for (int k = 0; k < 14; k++) begin
      din[0] = 8'($urandom);
      @(negedge clk);
      if (acc_cnt[0] != prev) begin
        chk("d4_ready_low", 0, rdy[0], 1'b0);
        prev = acc_cnt[0];
      end
    end
    vin[0] = 1'b0;
    wait_cycles(12);
    chk_int("d4_nbits", obs_n[0], 4 * (acc_cnt[0] - c0));

    // Reset mid-frame with a word waiting in the hold buffer.
    clear_obs(0);
    send(0, 8'h0F);
    send(0, 8'h03);
    for (int k = 0; k < 20 && obs_n[0] < 2; k++) @(negedge clk);
    chk_int("d5_bits_before", obs_n[0], 2);
    #2 rst_bar = 1'b0;
    #1;
    chk("d5_valid", 0, sv[0], 1'b0);
    chk("d5_out", 0, so[0], 1'b0);
    chk("d5_busy", 0, bsy[0], 1'b0);
    chk("d5_ready", 0, rdy[0], 1'b1);
    chk("d5_s_lbar", 0, slb[0], 1'b1);
    wait_cycles(2);
    #2 rst_bar = 1'b1;
    clear_obs(0);
    send(0, 8'h06);
    wait_cycles(10);
    chk_int("d5_nbits", obs_n[0], 4);
    chk_int("d5_bits", int'(obs_bits[0][3:0]), 4'b0110);

    // WIDTH=8 word 81.
    clear_obs(2);
    send(2, 8'h81);
    wait_cycles(12);
    chk_int("d6_nbits", obs_n[2], 8);
    chk_int("d6_bits", int'(obs_bits[2][7:0]), 8'h81);
    chk_int("d6_last_pos", obs_l0[2] - obs_f0[2], 7);
    chk_int("d6_lasts", obs_lc[2], 1);

    // Randomized traffic at varying density, with one asynchronous reset pulse.
    dens = 90;
    for (int k = 0; k < 1500; k++) begin
      if (k == 500) dens = 30;
      if (k == 1000) dens = 60;
      for (int i = 0; i < 3; i++) begin
        vin[i] = ($urandom_range(0, 99) < dens);
        din[i] = 8'($urandom);
      end
      if (k == 1200) begin
        #3 rst_bar = 1'b0;
        #4 rst_bar = 1'b1;
      end
      @(negedge clk);
    end
    vin = '0;
    wait_cycles(20);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
